// File: rtl/rtc_bcd_field_if.sv
// ---------------------------------------------------------------------------
// rtc_bcd_field_if
// Bundles the key, load, tick and output signals of one RTC BCD time field.
//   master : drives UP, DOWN, MOD_EN, LOAD, DATA_in, TICK;
//            observes DATA_out, CARRY, LOAD_ERR
//   slave  : the field register itself (opposite directions)
// Parameter DIGITS sets the packed-BCD width W = 4*DIGITS.
// ---------------------------------------------------------------------------
interface rtc_bcd_field_if #(
    parameter int DIGITS = 2
);
    localparam int W = 4 * DIGITS;

    logic         UP;
    logic         DOWN;
    logic         MOD_EN;
    logic         LOAD;
    logic [W-1:0] DATA_in;
    logic         TICK;
    logic [W-1:0] DATA_out;
    logic         CARRY;
    logic         LOAD_ERR;

    modport master (
        output UP, DOWN, MOD_EN, LOAD, DATA_in, TICK,
        input  DATA_out, CARRY, LOAD_ERR
    );

    modport slave (
        input  UP, DOWN, MOD_EN, LOAD, DATA_in, TICK,
        output DATA_out, CARRY, LOAD_ERR
    );
endinterface

// File: rtl/rtc_bcd_field.sv
// ---------------------------------------------------------------------------
// rtc_bcd_field
// One packed-BCD RTC time field (seconds, minutes, hours, ...) holding a value
// in [MIN_BCD, MAX_BCD]. Supports key editing with hold-to-repeat while
// MOD_EN=1, range/digit-checked bulk LOAD and TICK counting with a CARRY
// pulse for cascading fields when MOD_EN=0.
// Ports:
//   CLK  - system clock
//   RST  - asynchronous active-high reset
//   bus  - rtc_bcd_field_if.slave (keys, load, tick, value/carry/error out)
// All outputs are registered.
// ---------------------------------------------------------------------------
module rtc_bcd_field #(
    parameter int                  DIGITS  = 2,
    parameter logic [4*DIGITS-1:0] MIN_BCD = 8'h00,
    parameter logic [4*DIGITS-1:0] MAX_BCD = 8'h59,
    parameter logic [4*DIGITS-1:0] RST_BCD = 8'h00,
    parameter logic [23:0]         REP_DLY = 24'd25_000_000,
    parameter logic [23:0]         REP_PER = 24'd5_000_000
) (
    input  logic           CLK,
    input  logic           RST,
    rtc_bcd_field_if.slave bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_t;

    key_state_t   state_r, state_s;
    logic [23:0]  cnt_r, cnt_s;
    logic         dir_r, dir_s;        // 1 = current hold is an UP hold
    logic         up_prev_r, dn_prev_r;
    logic         arm_r;               // set once keys seen released after reset
    logic         key_act_s, key_up_s, edge_s;
    logic         step_s;
    logic [W-1:0] data_r, data_s;
    logic         carry_r, carry_s;
    logic         err_r, err_s;

    // BCD +1 with per-digit carry; MAX_BCD wraps to MIN_BCD.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        if (v >= MAX_BCD) begin
            r = MIN_BCD;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (c) begin
                    if (v[4*i +: 4] >= 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    r[4*i +: 4] = v[4*i +: 4];
                end
            end
        end
        return r;
    endfunction

    // BCD -1 with per-digit borrow; MIN_BCD wraps to MAX_BCD.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        if (v <= MIN_BCD) begin
            r = MAX_BCD;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (b) begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        b = 1'b0;
                    end
                end else begin
                    r[4*i +: 4] = v[4*i +: 4];
                end
            end
        end
        return r;
    endfunction

    // True when every nibble is a decimal digit and the value is in range.
    function automatic logic bcd_load_ok(input logic [W-1:0] v);
        logic ok;
        ok = (v >= MIN_BCD) && (v <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // UP dominates DOWN. An edge only counts once the keys have been seen
    // released after reset, so a key held through reset cannot restart a step.
    assign key_act_s = bus.UP | bus.DOWN;
    assign key_up_s  = bus.UP;
    assign edge_s    = arm_r & ((bus.UP & ~up_prev_r) |
                                (~bus.UP & bus.DOWN & ~dn_prev_r));

    // Key FSM next state, repeat counter and step request.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        dir_s   = dir_r;
        step_s  = 1'b0;
        if (!bus.MOD_EN) begin
            state_s = ST_IDLE;
            cnt_s   = 24'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        step_s  = 1'b1;
                        cnt_s   = 24'd0;
                        dir_s   = key_up_s;
                        state_s = ST_HOLD;
                    end else begin
                        cnt_s   = 24'd0;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!key_act_s) begin
                        state_s = ST_IDLE;
                        cnt_s   = 24'd0;
                    end else if (key_up_s != dir_r) begin
                        // direction swap: immediate step, restart the delay
                        step_s  = 1'b1;
                        cnt_s   = 24'd0;
                        dir_s   = key_up_s;
                        state_s = ST_HOLD;
                    end else if (cnt_r == ((state_r == ST_HOLD) ? (REP_DLY - 24'd1)
                                                                : (REP_PER - 24'd1))) begin
                        step_s  = 1'b1;
                        cnt_s   = 24'd0;
                        state_s = ST_REPEAT;
                    end else begin
                        cnt_s   = cnt_r + 24'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 24'd0;
                end
            endcase
        end
    end

    // Field value next state: edit step, then LOAD, then TICK.
    always_comb begin
        data_s  = data_r;
        carry_s = 1'b0;
        err_s   = 1'b0;
        if (step_s) begin
            data_s = dir_s ? bcd_inc(data_r) : bcd_dec(data_r);
        end else if (!bus.MOD_EN && bus.LOAD) begin
            if (bcd_load_ok(bus.DATA_in)) begin
                data_s = bus.DATA_in;
            end else begin
                err_s  = 1'b1;
            end
        end else if (!bus.MOD_EN && bus.TICK) begin
            data_s  = bcd_inc(data_r);
            carry_s = (data_r >= MAX_BCD);
        end else begin
            data_s  = data_r;
        end
    end

    // Key FSM, counter and key-history registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 24'd0;
            dir_r     <= 1'b0;
            up_prev_r <= 1'b0;
            dn_prev_r <= 1'b0;
            arm_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            dir_r     <= dir_s;
            up_prev_r <= bus.UP;
            dn_prev_r <= bus.DOWN;
            arm_r     <= arm_r | ~key_act_s;
        end
    end

    // Value and pulse output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_r  <= RST_BCD;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            data_r  <= data_s;
            carry_r <= carry_s;
            err_r   <= err_s;
        end
    end

    assign bus.DATA_out = data_r;
    assign bus.CARRY    = carry_r;
    assign bus.LOAD_ERR = err_r;

endmodule

// File: tb/tb_rtc_bcd_field.sv
// ---------------------------------------------------------------------------
// tb_rtc_bcd_field
// Directed self-checking bench for rtc_bcd_field using three instances:
// seconds-style 00..59 with short repeat timing, month 01..12, hours 00..23.
// ---------------------------------------------------------------------------
module tb_rtc_bcd_field;
    logic CLK;
    logic RST;

    int n_tests;
    int n_fail;

    rtc_bcd_field_if #(.DIGITS(2)) sec_if ();
    rtc_bcd_field_if #(.DIGITS(2)) mon_if ();
    rtc_bcd_field_if #(.DIGITS(2)) hr_if ();

    rtc_bcd_field #(.DIGITS(2), .MIN_BCD(8'h00), .MAX_BCD(8'h59), .RST_BCD(8'h00),
                    .REP_DLY(24'd10), .REP_PER(24'd4))
        u_sec (.CLK(CLK), .RST(RST), .bus(sec_if));

    rtc_bcd_field #(.DIGITS(2), .MIN_BCD(8'h01), .MAX_BCD(8'h12), .RST_BCD(8'h01),
                    .REP_DLY(24'd10), .REP_PER(24'd4))
        u_mon (.CLK(CLK), .RST(RST), .bus(mon_if));

    rtc_bcd_field #(.DIGITS(2), .MIN_BCD(8'h00), .MAX_BCD(8'h23), .RST_BCD(8'h00),
                    .REP_DLY(24'd10), .REP_PER(24'd4))
        u_hr (.CLK(CLK), .RST(RST), .bus(hr_if));

    // free-running clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       mod_en;
        logic       load;
        logic       tick;
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_carry;
        logic       exp_err;
    } vec_t;

    vec_t tbl[14];

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // number of repeat steps applied by the clock k cycles after the press
    function automatic int rep_steps(input int k);
        int s;
        s = 0;
        if (k >= 0)  s++;
        if (k >= 10) s++;
        if (k >= 14) s++;
        if (k >= 18) s++;
        if (k >= 22) s++;
        if (k >= 26) s++;
        return s;
    endfunction

    task automatic idle_all();
        sec_if.UP = 1'b0; sec_if.DOWN = 1'b0; sec_if.MOD_EN = 1'b0;
        sec_if.LOAD = 1'b0; sec_if.TICK = 1'b0; sec_if.DATA_in = 8'h00;
        mon_if.UP = 1'b0; mon_if.DOWN = 1'b0; mon_if.MOD_EN = 1'b0;
        mon_if.LOAD = 1'b0; mon_if.TICK = 1'b0; mon_if.DATA_in = 8'h00;
        hr_if.UP = 1'b0; hr_if.DOWN = 1'b0; hr_if.MOD_EN = 1'b0;
        hr_if.LOAD = 1'b0; hr_if.TICK = 1'b0; hr_if.DATA_in = 8'h00;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //            mod_en load  tick  din    data   carry err
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h17, 8'h17, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h24, 8'h17, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h1A, 8'h17, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h17, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h18, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h23, 8'h23, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h09, 8'h09, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h09, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h05, 8'h09, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h9F, 8'h09, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0};

        idle_all();
        RST = 1'b1;
        cyc();
        cyc();
        RST = 1'b0;

        // reset values
        check("rst_sec_data", sec_if.DATA_out, 8'h00);
        check("rst_sec_carry", {7'd0, sec_if.CARRY}, 8'h00);
        check("rst_sec_err", {7'd0, sec_if.LOAD_ERR}, 8'h00);
        check("rst_mon_data", mon_if.DATA_out, 8'h01);
        cyc();

        // 60 ticks: 01..59 then wrap to 00 with a single CARRY
        for (int i = 1; i <= 60; i++) begin
            sec_if.TICK = 1'b1;
            cyc();
            check($sformatf("tick%0d_data", i), sec_if.DATA_out, to_bcd(i % 60));
            check($sformatf("tick%0d_carry", i), {7'd0, sec_if.CARRY}, (i == 60) ? 8'h01 : 8'h00);
        end
        sec_if.TICK = 1'b0;
        cyc();
        check("tick_after_carry", {7'd0, sec_if.CARRY}, 8'h00);
        check("tick_after_data", sec_if.DATA_out, 8'h00);

        // month field manual wrap both ways and digit carry
        mon_if.LOAD = 1'b1; mon_if.DATA_in = 8'h12;
        cyc();
        check("mon_load12", mon_if.DATA_out, 8'h12);
        mon_if.LOAD = 1'b0; mon_if.MOD_EN = 1'b1;
        cyc();
        mon_if.UP = 1'b1;
        cyc();
        check("mon_up_wrap", mon_if.DATA_out, 8'h01);
        check("mon_up_wrap_carry", {7'd0, mon_if.CARRY}, 8'h00);
        mon_if.UP = 1'b0;
        cyc();
        mon_if.DOWN = 1'b1;
        cyc();
        check("mon_dn_wrap", mon_if.DATA_out, 8'h12);
        check("mon_dn_wrap_carry", {7'd0, mon_if.CARRY}, 8'h00);
        mon_if.DOWN = 1'b0;
        cyc();
        mon_if.MOD_EN = 1'b0; mon_if.LOAD = 1'b1; mon_if.DATA_in = 8'h09;
        cyc();
        check("mon_load09", mon_if.DATA_out, 8'h09);
        mon_if.LOAD = 1'b0; mon_if.MOD_EN = 1'b1;
        cyc();
        mon_if.UP = 1'b1;
        cyc();
        check("mon_up_09_10", mon_if.DATA_out, 8'h10);
        check("mon_up_09_10_carry", {7'd0, mon_if.CARRY}, 8'h00);
        mon_if.UP = 1'b0;
        cyc();
        check("mon_release", mon_if.DATA_out, 8'h10);
        mon_if.MOD_EN = 1'b0;

        // hours field: load/tick table
        for (int v = 0; v < 14; v++) begin
            hr_if.MOD_EN  = tbl[v].mod_en;
            hr_if.LOAD    = tbl[v].load;
            hr_if.TICK    = tbl[v].tick;
            hr_if.DATA_in = tbl[v].din;
            cyc();
            check($sformatf("tbl%0d_data", v), hr_if.DATA_out, tbl[v].exp_data);
            check($sformatf("tbl%0d_carry", v), {7'd0, hr_if.CARRY}, {7'd0, tbl[v].exp_carry});
            check($sformatf("tbl%0d_err", v), {7'd0, hr_if.LOAD_ERR}, {7'd0, tbl[v].exp_err});
        end
        hr_if.MOD_EN = 1'b0; hr_if.LOAD = 1'b0; hr_if.TICK = 1'b0;

        // LOAD beats TICK at 59; TICK ignored in edit mode
        sec_if.LOAD = 1'b1; sec_if.DATA_in = 8'h59;
        cyc();
        check("sec_load59", sec_if.DATA_out, 8'h59);
        sec_if.TICK = 1'b1; sec_if.DATA_in = 8'h30;
        cyc();
        check("load_tick_data", sec_if.DATA_out, 8'h30);
        check("load_tick_carry", {7'd0, sec_if.CARRY}, 8'h00);
        sec_if.LOAD = 1'b0; sec_if.MOD_EN = 1'b1;
        cyc();
        check("edit_tick_data", sec_if.DATA_out, 8'h30);
        check("edit_tick_carry", {7'd0, sec_if.CARRY}, 8'h00);
        sec_if.TICK = 1'b0; sec_if.MOD_EN = 1'b0;
        sec_if.LOAD = 1'b1; sec_if.DATA_in = 8'h00;
        cyc();
        check("sec_load00", sec_if.DATA_out, 8'h00);
        sec_if.LOAD = 1'b0; sec_if.MOD_EN = 1'b1;
        cyc();

        // hold UP 30 cycles: steps at clocks 0,10,14,18,22,26 after press
        sec_if.UP = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cyc();
            check($sformatf("rep%0d", k), sec_if.DATA_out, to_bcd(rep_steps(k)));
        end
        sec_if.UP = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check($sformatf("rep_rel%0d", k), sec_if.DATA_out, 8'h06);
        end

        // reset in the middle of a repeat with UP held
        sec_if.UP = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            cyc();
            check($sformatf("prerst%0d", k), sec_if.DATA_out,
                  to_bcd(6 + ((k >= 0) ? 1 : 0) + ((k >= 10) ? 1 : 0) + ((k >= 14) ? 1 : 0)));
        end
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_data", sec_if.DATA_out, 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            check($sformatf("held_after_rst%0d", k), sec_if.DATA_out, 8'h00);
        end
        sec_if.UP = 1'b0;
        cyc();
        cyc();
        check("rst_release_up", sec_if.DATA_out, 8'h00);
        sec_if.UP = 1'b1;
        cyc();
        check("repress_step", sec_if.DATA_out, 8'h01);
        sec_if.UP = 1'b0;
        cyc();
        check("repress_release", sec_if.DATA_out, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
